ibex_bloom_ctrl: RTL

// Sequencer for the EX-stage Bloom-filter custom-instruction unit. Accepts INSERT/CHECK/CLEAR ops

---
 rtl/ibex_bloom_pkg.sv | 35 +++
 rtl/ibex_bloom_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ibex_bloom_pkg.sv
// Shared types and the key hash for the EX-stage Bloom-filter sequencer.
package ibex_bloom_pkg;

  typedef enum logic [4:0] {
    OP_INSERT = 5'd1,
    OP_CHECK  = 5'd2,
    OP_CLEAR  = 5'd3
  } bloom_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_WR   = 3'd3,
    S_CLR  = 3'd4,
    S_RESP = 3'd5
  } bloom_state_e;

  localparam logic [31:0] BloomGolden = 32'h9E3779B9;

  // Bit index for hash k, returned in the low idx_w bits (upper bits zero).
  function automatic logic [31:0] bloom_hash(input logic [31:0] key,
                                             input logic [31:0] seed,
                                             input logic [2:0]  k,
                                             input int          idx_w);
    logic [4:0]  w_sh;
    logic [31:0] w_rot;
    logic [31:0] w_h;
    w_sh  = {k[1:0], 3'b000};
    w_rot = (seed << w_sh) | (seed >> (6'd32 - {1'b0, w_sh}));
    w_h   = key ^ w_rot ^ ((BloomGolden * {29'd0, k}) + BloomGolden);
    return (w_h ^ (w_h >> (32 - idx_w))) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/ibex_bloom_ctrl.sv
// Bloom-filter op sequencer: hashes the key and runs read-modify-write or
// clear sweeps on an external single-port bit-array RAM.
module ibex_bloom_ctrl
  import ibex_bloom_pkg::*;
#(
  parameter int unsigned NumBits   = 1024,
  parameter int unsigned WordW     = 32,
  parameter int unsigned NumHashes = 3,
  parameter int unsigned CntW      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [4:0]                            req_op_i,
  input  logic [31:0]                           req_key_i,
  input  logic [31:0]                           req_seed_i,
  input  logic                                  flush_i,
  output logic                                  resp_valid_o,
  output logic [31:0]                           resp_result_o,
  output logic                                  resp_err_o,
  output logic                                  busy_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [$clog2(NumBits/WordW)-1:0]      mem_addr_o,
  output logic [WordW-1:0]                      mem_wdata_o,
  input  logic [WordW-1:0]                      mem_rdata_i,
  output logic [CntW-1:0]                       insert_cnt_o
);

  localparam int         AddrW = $clog2(NumBits / WordW);
  localparam int         BitW  = $clog2(WordW);
  localparam int         IdxW  = $clog2(NumBits);
  localparam logic [2:0] KLast = 3'(NumHashes - 1);

  bloom_state_e r_state;
  bloom_state_e w_state_next;
  logic [4:0]       r_op;
  logic [31:0]      r_key;
  logic [31:0]      r_seed;
  logic [2:0]       r_k;
  logic             r_hit;
  logic             r_err;
  logic [WordW-1:0] r_rdata;
  logic [AddrW-1:0] r_clr_addr;
  logic [CntW-1:0]  r_cnt;

  logic [IdxW-1:0]  w_idx;
  logic [AddrW-1:0] w_word;
  logic [BitW-1:0]  w_bit;
  logic             w_bit_set;
  logic             w_k_last;
  logic             w_clr_last;
  logic             w_accept;
  logic             w_is_lookup;

  assign w_idx       = IdxW'(bloom_hash(r_key, r_seed, r_k, IdxW));
  assign w_word      = w_idx[IdxW-1:BitW];
  assign w_bit       = w_idx[BitW-1:0];
  assign w_bit_set   = mem_rdata_i[w_bit];
  assign w_k_last    = (r_k == KLast);
  assign w_clr_last  = (r_clr_addr == {AddrW{1'b1}});
  assign w_accept    = (r_state == S_IDLE) & req_valid_i;
  assign w_is_lookup = (r_op == OP_INSERT) | (r_op == OP_CHECK);

  // Next-state decode; flush only kills the hash/RMW states.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          case (req_op_i)
            OP_INSERT, OP_CHECK: w_state_next = S_RD;
            OP_CLEAR:            w_state_next = S_CLR;
            default:             w_state_next = S_RESP;
          endcase
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RD: begin
        if (flush_i) w_state_next = S_IDLE;
        else         w_state_next = S_CHK;
      end
      S_CHK: begin
        if (flush_i)                         w_state_next = S_IDLE;
        else if (r_op == OP_INSERT)          w_state_next = S_WR;
        else if (!w_bit_set || w_k_last)     w_state_next = S_RESP;
        else                                 w_state_next = S_RD;
      end
      S_WR: begin
        if (flush_i)       w_state_next = S_IDLE;
        else if (w_k_last) w_state_next = S_RESP;
        else               w_state_next = S_RD;
      end
      S_CLR: begin
        if (w_clr_last) w_state_next = S_RESP;
        else            w_state_next = S_CLR;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, request latch, hash progress, clear sweep and insert counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_op       <= 5'd0;
      r_key      <= 32'd0;
      r_seed     <= 32'd0;
      r_k        <= 3'd0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= {WordW{1'b0}};
      r_clr_addr <= {AddrW{1'b0}};
      r_cnt      <= {CntW{1'b0}};
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op       <= req_op_i;
        r_key      <= req_key_i;
        r_seed     <= req_seed_i;
        r_k        <= 3'd0;
        r_hit      <= 1'b1;
        r_clr_addr <= {AddrW{1'b0}};
        r_err      <= !((req_op_i == OP_INSERT) || (req_op_i == OP_CHECK) ||
                        (req_op_i == OP_CLEAR));
      end
      if ((r_state == S_CHK) && !flush_i) begin
        r_hit   <= r_hit & w_bit_set;
        r_rdata <= mem_rdata_i;
      end
      if ((w_state_next == S_RD) && (r_state != S_IDLE)) begin
        r_k <= r_k + 3'd1;
      end
      if (r_state == S_CLR) begin
        r_clr_addr <= r_clr_addr + AddrW'(1);
      end
      // A completed CLEAR wins over the counter; the two cannot coincide anyway.
      if ((r_state == S_CLR) && w_clr_last) begin
        r_cnt <= {CntW{1'b0}};
      end else if ((r_state == S_RESP) && (r_op == OP_INSERT) &&
                   (r_cnt != {CntW{1'b1}})) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign req_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign mem_req_o     = (((r_state == S_RD) || (r_state == S_WR)) && !flush_i) ||
                         (r_state == S_CLR);
  assign mem_we_o      = ((r_state == S_WR) && !flush_i) || (r_state == S_CLR);
  assign mem_addr_o    = (r_state == S_CLR) ? r_clr_addr :
                         ((r_state == S_RD) || (r_state == S_WR)) ? w_word :
                         {AddrW{1'b0}};
  assign mem_wdata_o   = (r_state == S_WR) ? (r_rdata | (WordW'(1) << w_bit)) :
                         {WordW{1'b0}};
  assign resp_valid_o  = (r_state == S_RESP);
  assign resp_err_o    = (r_state == S_RESP) & r_err;
  assign resp_result_o = {31'd0, (r_state == S_RESP) & w_is_lookup & r_hit};
  assign insert_cnt_o  = r_cnt;

endmodule
